// File: rtl/matmul_pkg.sv
// Shared state encoding, parameter defaults and index-width helper for the
// matrix-multiply sequencer.
package matmul_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_N     = 4;
    localparam int DEF_ACC_W     = 18;
    localparam int DEF_RES_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        SEND
    } state_t;

    // Width of a counter that indexes 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Host-facing byte bus of the sequencer: UART rx strobe, tx handshake and status.
interface matmul_seq_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, busy, done, err
    );

endinterface

// File: rtl/matmul_mac.sv
// Registered unsigned multiply-accumulate, time-shared across all C elements.
// Clear takes priority over enable.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Byte-protocol sequencer: size, A, B in; C = A x B out as big-endian bytes.
// Optional inter-byte load timeout enabled by defining MATMUL_RX_TIMEOUT_EN.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_N     = DEF_MAX_N,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int RES_BYTES = DEF_RES_BYTES
`ifdef MATMUL_RX_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input logic             clk,
    input logic             rst,
    matmul_seq_ctrl_if.slave bus
);

    localparam int IDX_W  = idx_w(MAX_N);
    localparam int BYTE_W = idx_w(RES_BYTES);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       n_m1, r, c, i, j, k;
    logic [BYTE_W-1:0]      b;
    logic                   err_q, done_q;
    logic [DATA_W-1:0]      mem_a [MAX_N][MAX_N];
    logic [DATA_W-1:0]      mem_b [MAX_N][MAX_N];
    logic [ACC_W-1:0]       acc;
    logic [8*RES_BYTES-1:0] res_pad;
    logic [7:0]             tx_byte;
    logic mac_clr, mac_en, size_ok, load_last, k_last, b_last, elem_last, xfer, timeout;

    assign size_ok   = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= MAX_N);
    assign load_last = (r == n_m1) && (c == n_m1);
    assign k_last    = (k == n_m1);
    assign b_last    = (b == BYTE_W'(RES_BYTES - 1));
    assign elem_last = (i == n_m1) && (j == n_m1);
    assign xfer      = (state_q == SEND) && bus.tx_ready;

`ifdef MATMUL_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            loading;

    assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign timeout = loading && !bus.rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (!loading || bus.rx_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TO_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            IDLE:   if (bus.rx_valid && size_ok) state_d = LOAD_A;
            LOAD_A: begin
                if (timeout)                         state_d = IDLE;
                else if (bus.rx_valid && load_last)  state_d = LOAD_B;
            end
            LOAD_B: begin
                if (timeout) state_d = IDLE;
                else if (bus.rx_valid && load_last) begin
                    state_d = CALC;
                    mac_clr = 1'b1;
                end
            end
            CALC: begin
                mac_en = 1'b1;
                if (k_last) state_d = SEND;
            end
            SEND: begin
                if (xfer && b_last) begin
                    if (elem_last) state_d = IDLE;
                    else begin
                        state_d = CALC;
                        mac_clr = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_m1 <= '0; r <= '0; c <= '0; i <= '0; j <= '0; k <= '0; b <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.rx_valid) begin
                    if (size_ok) begin
                        n_m1  <= IDX_W'(bus.rx_data - 8'd1);
                        err_q <= 1'b0;
                        r <= '0; c <= '0; i <= '0; j <= '0; k <= '0; b <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (timeout) err_q <= 1'b1;
                    else if (bus.rx_valid) begin
                        if (c == n_m1) begin
                            c <= '0;
                            r <= (r == n_m1) ? '0 : r + IDX_W'(1);
                        end else begin
                            c <= c + IDX_W'(1);
                        end
                    end
                end
                CALC: k <= k_last ? '0 : k + IDX_W'(1);
                SEND: if (xfer) begin
                    if (b_last) begin
                        b <= '0;
                        if (elem_last) begin
                            i <= '0; j <= '0;
                            done_q <= 1'b1;
                        end else if (j == n_m1) begin
                            j <= '0;
                            i <= i + IDX_W'(1);
                        end else begin
                            j <= j + IDX_W'(1);
                        end
                    end else begin
                        b <= b + BYTE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand storage has no reset; only the N x N corner written by
    // the current load is ever read, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && state_q == LOAD_A) mem_a[r][c] <= DATA_W'(bus.rx_data);
        if (bus.rx_valid && state_q == LOAD_B) mem_b[r][c] <= DATA_W'(bus.rx_data);
    end

    matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mem_a[i][k]),
        .b   (mem_b[k][j]),
        .acc (acc)
    );

    always_comb begin
        res_pad = '0;
        res_pad[ACC_W-1:0] = acc;
    end

    assign tx_byte      = 8'(res_pad >> (8 * (RES_BYTES - 1 - int'(b))));
    assign bus.tx_data  = (state_q == SEND) ? tx_byte : 8'd0;
    assign bus.tx_valid = (state_q == SEND);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer between the UART byte receiver/transmitter and the matrix-multiply arithmetic.
- Accepts a size byte N, then N*N bytes of A and N*N bytes of B (row-major), then computes C = A x B with one time-shared multiply-accumulate unit.
- Streams each C element to the UART TX side as fixed-width big-endian bytes.
- Owns all operand storage, loop counters and the host-facing byte protocol.

Parameters:
- DATA_W, 8, operand width (one UART byte per element).
- MAX_N, 4, largest accepted matrix dimension.
- ACC_W, 18, accumulator width; must be >= 2*DATA_W + clog2(MAX_N).
- RES_BYTES, 3, bytes sent per C element, equal to ceil(ACC_W/8).
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter can accept; a transfer happens when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte of C is accepted.
- err  out  1  sticky; set on an illegal size byte or a timeout, cleared by the next legal size byte.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all counters and the accumulator = 0; tx_valid=0, tx_data=0, busy=0, done=0, err=0. Operand storage is not cleared.
- IDLE: on rx_valid, latch N=rx_data.
  - 1<=N<=MAX_N: clear err, zero counters, go to LOAD_A.
  - Otherwise: set err, stay in IDLE.
- LOAD_A: each rx_valid writes A[r][c] and advances c, then r. After N*N bytes, go to LOAD_B.
- LOAD_B: same indexing into B. After N*N bytes, go to CALC with i=j=k=0 and acc=0.
- CALC: one MAC per cycle, acc += A[i][k]*B[k][j] (unsigned, zero-extended to ACC_W). When k=N-1, the next cycle goes to SEND with the final value; N cycles per element.
- SEND:
  - Present the result MSB byte first: tx_data = result[8*(RES_BYTES-1-b) +: 8], upper bits zero-padded. Assert tx_valid.
  - Hold tx_data and tx_valid stable until tx_ready; advance b on each transfer.
  - After RES_BYTES transfers, move to the next element: j++, wrapping to 0 with i++.
  - If elements remain: back to CALC with acc=0, k=0, tx_valid deasserted.
  - After element (N-1,N-1): pulse done for one cycle, go to IDLE.
- Output order: row-major C[0][0], C[0][1], ..., C[N-1][N-1].
- rx_valid during CALC or SEND: byte ignored, no state change.
- rx_valid in the same cycle as the final LOAD_B byte: only that byte is consumed.
- Minimum tx_valid-to-tx_valid gap between elements: N+1 cycles.
- Matrix indices occupy only the N x N corner of MAX_N x MAX_N storage; stale entries outside it are never read.

Optional Feature:
- Macro: MATMUL_RX_TIMEOUT_EN.
- When defined: in LOAD_A or LOAD_B, an idle counter resets on every rx_valid. Reaching TIMEOUT_CYC sets err and returns to IDLE; received data is abandoned and no bytes are transmitted.
- When undefined: no counter, and LOAD states wait indefinitely.

Decomposition:
- Shared package matmul_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, CALC, SEND);
  - DATA_W, MAX_N, ACC_W and RES_BYTES defaults;
  - the clog2-derived index width.
- One natural sub-module: matmul_mac. It is a registered multiply-accumulate with clear and enable inputs and an ACC_W-wide output, and is instantiated once.

Test Plan:
- Size 02, A=01 02 03 04, B=05 06 07 08 -> tx bytes 00 00 13, 00 00 16, 00 00 2B, 00 00 32; done pulses once; busy returns low.
- Size 03, A=01 02 03 04 03 04 04 03 04, B=05 06 07 08 07 08 08 07 08 -> C=45,41,47,76,73,84,76,73,84, i.e. 00 00 2D, 00 00 29, 00 00 2F, 00 00 4C, 00 00 49, 00 00 54, then the row repeats.
- Size 04, all operands FF -> sixteen elements, each sent as 03 F8 04 (260100); no overflow.
- Size 00, then size 05 -> err=1, no tx_valid, state stays IDLE. A following size 01, A=07, B=06 -> err clears, tx 00 00 2A.
- Size 02 case with tx_ready held low for 50 cycles during the second byte -> tx_data stable, no byte lost or duplicated. Extra rx bytes injected during SEND are ignored.
- rst asserted mid-SEND (after 1 byte) -> outputs zero immediately. A fresh size 01, A=02, B=03 then yields 00 00 06. With MATMUL_RX_TIMEOUT_EN and TIMEOUT_CYC=100, stalling after 2 A bytes sets err and returns to IDLE.
